line_buffer_scheduler: RTL and testbench
========================================

# line_buffer_scheduler

Sequences the two-bank (ping-pong) line buffer that feeds the VGA output stage. It requests a framebuffer fill of the next source line into the idle bank while the VGA stage scans the other bank. It swaps banks after each source line has been displayed twice (2x vertical line doubling). It sits between the framebuffer reader (fill handshake) and the VGA generator (`line_finished`, bank select).

## Interface
Parameters:
- `SOURCE_LINES`, 240, source lines per frame; each is shown on two VGA lines.
- `LINE_INDEX_WIDTH`, 8, width of `fill_line`; must hold `SOURCE_LINES-1`.

Ports:
- `clock`  in  1  system/pixel clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  display enable; low forces IDLE.
- `frame_start`  in  1  one-cycle pulse at the start of the vertical blank preceding a frame.
- `line_finished`  in  1  one-cycle pulse from the VGA stage at the hsync falling edge of every visible line.
- `display_bank`  out  1  bank the VGA stage reads; the other bank is the fill target.
- `fill_request`  out  1  fill request, held until `fill_ack`.
- `fill_line`  out  LINE_INDEX_WIDTH  source line to load; stable while `fill_request` is high.
- `fill_bank`  out  1  bank to load; stable while `fill_request` is high.
- `fill_ack`  in  1  reader accepted the request.
- `fill_done`  in  1  one-cycle pulse when the accepted fill is fully written.
- `ready`  out  1  a bank holds valid data for display.
- `underrun`  out  1  one-cycle pulse when a swap occurs before the next line is loaded.
- `underrun_count`  out  8  saturating count of underruns; cleared only by `reset`.

## Operation
- States: IDLE, PRELOAD, DISPLAY, DRAIN.
- Internal state: `src_line` counter, `repeat` bit (0 = first showing, 1 = second), `next_loaded` flag, `pending` flag (a fill was acked but is not yet done), `discard` flag.
- One fill outstanding at most. No new request is raised while `fill_request` is high or `pending` is set.
- IDLE: `ready`=0. `frame_start` with `enable`=1 sets `src_line`=0, `repeat`=0, `display_bank`=0. It then requests line 0 into bank 0 and moves to PRELOAD.
- PRELOAD: on a valid `fill_done`:
  - `ready`=1.
  - Request line 1 into bank `~display_bank`.
  - Go to DISPLAY.
  - If `SOURCE_LINES`==1, go to DRAIN and issue no request.
- DISPLAY, on `line_finished`:
  - If `repeat`=0: set `repeat`=1.
  - If `repeat`=1: set `repeat`=0, toggle `display_bank`, increment `src_line`.
  - If `next_loaded`=0 at that swap: pulse `underrun` and increment `underrun_count` (saturate at 255). The swap happens regardless.
  - Then, if `src_line+1` < `SOURCE_LINES`, request `src_line+1` into the freed bank and clear `next_loaded`. Otherwise go to DRAIN.
- DISPLAY, on a valid `fill_done`: set `next_loaded`=1.
- DRAIN: the last line shows twice. Then, on `line_finished` with `repeat`=1, go to IDLE with `ready`=0 and `display_bank` unchanged.
- Validity of `fill_done`:
  - `fill_done` while `discard`=1 clears `discard` and `pending` and is otherwise ignored.
  - `fill_done` with `pending`=0 is ignored.
- `frame_start` in PRELOAD, DISPLAY or DRAIN restarts the frame, as from IDLE. If a fill is pending, set `discard` and delay the line 0 request until that stale `fill_done` arrives. An unacked `fill_request` is retargeted to line 0 / bank 0 in the same cycle.
- `enable`=0: go to IDLE next cycle.
  - `ready`=0; `fill_request` drops only if it is not yet acked (abort).
  - An acked fill sets `discard`.
  - `underrun_count` is kept.

## Timing
- Reset values: `display_bank`=0, `fill_request`=0, `fill_line`=0, `fill_bank`=0, `ready`=0, `underrun`=0, `underrun_count`=0. State resets to IDLE with all flags clear.
- `fill_request` rises 1 cycle after the triggering event (`frame_start`, valid `fill_done`, swap).
- `fill_request` falls the cycle after `fill_ack`=1 is sampled. `pending` is set in that same edge. `fill_ack` may be high in the same cycle `fill_request` rises.
- `display_bank` toggles 1 cycle after the swapping `line_finished`. The VGA stage must latch it at the start of the next visible line.
- `ready` rises 1 cycle after the PRELOAD `fill_done`.
- `underrun` pulses in the same cycle as the `display_bank` toggle.
- Simultaneous events:
  - `fill_done` and swapping `line_finished` in the same cycle: fill counts first, so no underrun.
  - `frame_start` with `line_finished`: `frame_start` wins.
  - `reset` overrides everything.

## Test plan
- Nominal: `SOURCE_LINES`=4, `fill_ack` 1 cycle after request, `fill_done` 20 cycles later, `line_finished` every 100 cycles. Expect requests for lines 0,1,2,3 into banks 0,1,0,1; `display_bank` toggling every 2nd `line_finished`; no underrun; IDLE after 8 `line_finished`.
- Underrun: delay `fill_done` for line 2 past the 2nd following `line_finished`. Expect `underrun`=1 for one cycle, `underrun_count`=1, swap still occurs.
- Same-cycle `fill_done` and swapping `line_finished` -> no `underrun`, `underrun_count` unchanged.
- `frame_start` mid-DISPLAY with line 3 acked but not done. Expect the stale `fill_done` ignored, then a request for line 0 / bank 0 one cycle later, `display_bank`=0.
- Saturation: force 260 underruns -> `underrun_count`=255.
- `reset` high mid-DISPLAY for 1 cycle -> all outputs at their reset values on the next edge; a `fill_done` arriving afterwards is ignored.

Source files
------------

// File: rtl/line_buffer_scheduler_if.sv
// line_buffer_scheduler_if: fill handshake to the framebuffer reader and line/bank signals to the VGA stage.
interface line_buffer_scheduler_if #(parameter int LINE_INDEX_WIDTH = 8);
  logic enable;
  logic frame_start;
  logic line_finished;
  logic fill_ack;
  logic fill_done;
  logic display_bank;
  logic fill_request;
  logic [LINE_INDEX_WIDTH-1:0] fill_line;
  logic fill_bank;
  logic ready;
  logic underrun;
  logic [7:0] underrun_count;
  modport master (
    input  enable, frame_start, line_finished, fill_ack, fill_done,
    output display_bank, fill_request, fill_line, fill_bank, ready, underrun, underrun_count
  );
  modport slave (
    output enable, frame_start, line_finished, fill_ack, fill_done,
    input  display_bank, fill_request, fill_line, fill_bank, ready, underrun, underrun_count
  );
endinterface

// File: rtl/line_buffer_scheduler.sv
// line_buffer_scheduler: ping-pong line buffer sequencing with 2x line doubling and underrun accounting.
module line_buffer_scheduler #(
  parameter int SOURCE_LINES     = 240,
  parameter int LINE_INDEX_WIDTH = 8
) (
  input logic clock,
  input logic reset,
  line_buffer_scheduler_if.master bus
);
  typedef enum logic [1:0] {IDLE, PRELOAD, DISPLAY, DRAIN} state_t;
  localparam logic [LINE_INDEX_WIDTH:0] LINES = (LINE_INDEX_WIDTH+1)'(SOURCE_LINES);
  state_t state_q;
  logic [LINE_INDEX_WIDTH-1:0] src_line_q, fill_line_q;
  logic repeat_q, next_loaded_q, pending_q, discard_q, wait_q;
  logic display_bank_q, fill_request_q, fill_bank_q, ready_q, underrun_q;
  logic [7:0] underrun_count_q;
  logic accept, fill_valid, stale, loaded, more;
  logic [LINE_INDEX_WIDTH:0] next2;
  assign accept     = fill_request_q && bus.fill_ack;
  assign fill_valid = bus.fill_done && pending_q && !discard_q;
  // a fill that will still be in flight after this edge and must be thrown away
  assign stale      = accept || (pending_q && !bus.fill_done);
  assign loaded     = next_loaded_q || fill_valid;
  assign next2      = {1'b0, src_line_q} + (LINE_INDEX_WIDTH+1)'(2);
  assign more       = next2 < LINES;
  assign bus.display_bank   = display_bank_q;
  assign bus.fill_request   = fill_request_q;
  assign bus.fill_line      = fill_line_q;
  assign bus.fill_bank      = fill_bank_q;
  assign bus.ready          = ready_q;
  assign bus.underrun       = underrun_q;
  assign bus.underrun_count = underrun_count_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      src_line_q       <= '0;
      repeat_q         <= 1'b0;
      next_loaded_q    <= 1'b0;
      pending_q        <= 1'b0;
      discard_q        <= 1'b0;
      wait_q           <= 1'b0;
      display_bank_q   <= 1'b0;
      fill_request_q   <= 1'b0;
      fill_line_q      <= '0;
      fill_bank_q      <= 1'b0;
      ready_q          <= 1'b0;
      underrun_q       <= 1'b0;
      underrun_count_q <= '0;
    end else begin
      underrun_q <= 1'b0;
      if (accept) begin
        fill_request_q <= 1'b0;
        pending_q      <= 1'b1;
      end else if (bus.fill_done && pending_q) begin
        pending_q <= 1'b0;
        discard_q <= 1'b0;
        if (wait_q) begin
          fill_request_q <= 1'b1;
          wait_q         <= 1'b0;
        end
      end
      if (!bus.enable) begin
        state_q        <= IDLE;
        ready_q        <= 1'b0;
        wait_q         <= 1'b0;
        fill_request_q <= 1'b0;
        if (stale) discard_q <= 1'b1;
      end else if (bus.frame_start) begin
        state_q        <= PRELOAD;
        src_line_q     <= '0;
        repeat_q       <= 1'b0;
        display_bank_q <= 1'b0;
        next_loaded_q  <= 1'b0;
        ready_q        <= 1'b0;
        fill_line_q    <= '0;
        fill_bank_q    <= 1'b0;
        fill_request_q <= !stale;
        discard_q      <= stale;
        wait_q         <= stale;
      end else begin
        case (state_q)
          PRELOAD: if (fill_valid) begin
            ready_q       <= 1'b1;
            next_loaded_q <= 1'b0;
            if (SOURCE_LINES > 1) begin
              state_q        <= DISPLAY;
              fill_request_q <= 1'b1;
              fill_line_q    <= LINE_INDEX_WIDTH'(1);
              fill_bank_q    <= !display_bank_q;
            end else state_q <= DRAIN;
          end
          DISPLAY: begin
            if (fill_valid) next_loaded_q <= 1'b1;
            if (bus.line_finished) begin
              repeat_q <= !repeat_q;
              if (repeat_q) begin
                display_bank_q <= !display_bank_q;
                src_line_q     <= src_line_q + LINE_INDEX_WIDTH'(1);
                if (!loaded) begin
                  underrun_q <= 1'b1;
                  if (underrun_count_q != 8'hff) underrun_count_q <= underrun_count_q + 8'd1;
                end
                if (stale) discard_q <= 1'b1;
                // the late line lands in a bank now on screen, so its successor waits for it
                if (more) begin
                  next_loaded_q  <= 1'b0;
                  fill_line_q    <= next2[LINE_INDEX_WIDTH-1:0];
                  fill_bank_q    <= display_bank_q;
                  fill_request_q <= !stale;
                  wait_q         <= stale;
                end else begin
                  state_q        <= DRAIN;
                  fill_request_q <= 1'b0;
                end
              end
            end
          end
          DRAIN: if (bus.line_finished) begin
            repeat_q <= !repeat_q;
            if (repeat_q) begin
              state_q <= IDLE;
              ready_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_line_buffer_scheduler.sv
// tb_line_buffer_scheduler: directed checks of the line buffer scheduler with SOURCE_LINES=4.
module tb_line_buffer_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  line_buffer_scheduler_if #(.LINE_INDEX_WIDTH(8)) bus ();
  line_buffer_scheduler #(.SOURCE_LINES(4), .LINE_INDEX_WIDTH(8)) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic req(input string tag, input int line, input int bank);
    check({tag, "_req"}, 32'(bus.fill_request), 1);
    check({tag, "_line"}, 32'(bus.fill_line), 32'(line));
    check({tag, "_bank"}, 32'(bus.fill_bank), 32'(bank));
  endtask
  task automatic ack();
    bus.fill_ack = 1'b1;
    tick(1);
    bus.fill_ack = 1'b0;
  endtask
  task automatic fdone();
    bus.fill_done = 1'b1;
    tick(1);
    bus.fill_done = 1'b0;
  endtask
  task automatic lf();
    bus.line_finished = 1'b1;
    tick(1);
    bus.line_finished = 1'b0;
    tick(2);
  endtask
  task automatic fs();
    bus.frame_start = 1'b1;
    tick(1);
    bus.frame_start = 1'b0;
  endtask
  task automatic reset_outputs(input string tag);
    check({tag, "_bank"}, 32'(bus.display_bank), 0);
    check({tag, "_req"}, 32'(bus.fill_request), 0);
    check({tag, "_line"}, 32'(bus.fill_line), 0);
    check({tag, "_fbank"}, 32'(bus.fill_bank), 0);
    check({tag, "_ready"}, 32'(bus.ready), 0);
    check({tag, "_urun"}, 32'(bus.underrun), 0);
    check({tag, "_ucnt"}, 32'(bus.underrun_count), 0);
  endtask
  initial begin
    bus.enable = 1'b0;
    bus.frame_start = 1'b0;
    bus.line_finished = 1'b0;
    bus.fill_ack = 1'b0;
    bus.fill_done = 1'b0;
    tick(2);
    reset_outputs("rst");
    rst = 1'b0;
    bus.enable = 1'b1;
    tick(1);
    // nominal frame: lines 0..3 into banks 0,1,0,1
    fs();
    req("nom_l0", 0, 0);
    check("nom_ready0", 32'(bus.ready), 0);
    ack();
    check("nom_ackdrop", 32'(bus.fill_request), 0);
    tick(5);
    fdone();
    check("nom_ready1", 32'(bus.ready), 1);
    req("nom_l1", 1, 1);
    ack();
    tick(3);
    fdone();
    lf();
    check("nom_nosw", 32'(bus.display_bank), 0);
    lf();
    check("nom_sw1", 32'(bus.display_bank), 1);
    check("nom_urun1", 32'(bus.underrun), 0);
    req("nom_l2", 2, 0);
    ack();
    fdone();
    lf();
    lf();
    check("nom_sw2", 32'(bus.display_bank), 0);
    req("nom_l3", 3, 1);
    ack();
    fdone();
    lf();
    lf();
    check("nom_sw3", 32'(bus.display_bank), 1);
    check("nom_noreq", 32'(bus.fill_request), 0);
    lf();
    check("nom_drain", 32'(bus.ready), 1);
    lf();
    check("nom_idle", 32'(bus.ready), 0);
    check("nom_bankkept", 32'(bus.display_bank), 1);
    check("nom_ucnt", 32'(bus.underrun_count), 0);
    // fill_done coinciding with the swapping line_finished
    fs();
    check("sc_bank0", 32'(bus.display_bank), 0);
    ack();
    fdone();
    req("sc_l1", 1, 1);
    ack();
    lf();
    bus.fill_done = 1'b1;
    bus.line_finished = 1'b1;
    tick(1);
    bus.fill_done = 1'b0;
    bus.line_finished = 1'b0;
    check("sc_urun", 32'(bus.underrun), 0);
    check("sc_ucnt", 32'(bus.underrun_count), 0);
    check("sc_bank", 32'(bus.display_bank), 1);
    req("sc_l2", 2, 0);
    // line 2 finishes too late: underrun, swap anyway, line 3 deferred until it lands
    ack();
    lf();
    bus.line_finished = 1'b1;
    tick(1);
    bus.line_finished = 1'b0;
    check("ur_pulse", 32'(bus.underrun), 1);
    check("ur_cnt", 32'(bus.underrun_count), 1);
    check("ur_bank", 32'(bus.display_bank), 0);
    check("ur_held", 32'(bus.fill_request), 0);
    tick(1);
    check("ur_onecyc", 32'(bus.underrun), 0);
    fdone();
    req("ur_l3", 3, 1);
    // restart with line 3 in flight: stale done swallowed, then line 0
    ack();
    fs();
    check("rs_bank", 32'(bus.display_bank), 0);
    check("rs_wait", 32'(bus.fill_request), 0);
    check("rs_ready", 32'(bus.ready), 0);
    tick(2);
    fdone();
    req("rs_l0", 0, 0);
    check("rs_stale", 32'(bus.ready), 0);
    ack();
    fdone();
    check("rs_ready1", 32'(bus.ready), 1);
    req("rs_l1", 1, 1);
    // reset mid-display with a fill in flight
    ack();
    lf();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    reset_outputs("mrst");
    fdone();
    check("mrst_ready", 32'(bus.ready), 0);
    check("mrst_req", 32'(bus.fill_request), 0);
    // saturation: three underruns per frame, 87 frames
    for (int f = 0; f < 87; f++) begin
      fs();
      ack();
      fdone();
      for (int l = 0; l < 8; l++) lf();
      if (f == 0) check("sat_first", 32'(bus.underrun_count), 3);
    end
    check("sat_cnt", 32'(bus.underrun_count), 255);
    check("sat_idle", 32'(bus.ready), 0);
    // disable aborts an unacked request and keeps the count
    fs();
    check("dis_req", 32'(bus.fill_request), 1);
    bus.enable = 1'b0;
    tick(1);
    check("dis_abort", 32'(bus.fill_request), 0);
    check("dis_cnt", 32'(bus.underrun_count), 255);
    check("dis_ready", 32'(bus.ready), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
